kernel_bc_start_fanout_fifo: RTL and testbench

- Parametrised start/token FIFO. One HLS dataflow producer feeds NUM_RD consumer processes, and each consumer reads every word independently.
- A slot is retired only once all readers have consumed it. This replaces chains of single-reader start FIFOs when one process starts several downstream processes.
- Adds an occupancy count and an almost-full flag for back-pressure tuning.

---
 rtl/kernel_bc_fifo_pkg.sv | 41 ++++
 rtl/kernel_bc_fanout_fifo_rd_ctrl.sv | 59 +++++
 rtl/kernel_bc_start_fanout_fifo.sv | 114 +++++++++++
 tb/tb_kernel_bc_start_fanout_fifo.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/kernel_bc_fifo_pkg.sv
// Shared helpers for the broadcast start FIFO: pointer wrap, maximum
// occupancy across readers, and parameter legality limits.
package kernel_bc_fifo_pkg;

    localparam int MAX_RD         = 8;
    localparam int MAX_ADDR_WIDTH = 8;
    localparam int MAX_CNT_W      = MAX_ADDR_WIDTH + 1;
    localparam int MIN_DEPTH      = 2;

    // Per-reader counts packed at a fixed stride so one function serves
    // every NUM_RD / ADDR_WIDTH combination.
    typedef logic [MAX_RD*MAX_CNT_W-1:0] cnt_vec_t;

    function automatic bit params_legal(input int addr_width, input int depth,
                                        input int num_rd, input int afull_thresh);
        return (addr_width >= 1) && (addr_width <= MAX_ADDR_WIDTH) &&
               (depth >= MIN_DEPTH) && (depth <= (1 << addr_width)) &&
               (num_rd >= 1) && (num_rd <= MAX_RD) &&
               (afull_thresh >= 1) && (afull_thresh <= depth);
    endfunction

    // Mod-depth increment; depth need not be a power of two.
    function automatic int ptr_inc(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

    // Largest of the first num_rd counts in the packed vector.
    function automatic int max_cnt(input cnt_vec_t cnts, input int num_rd);
        int m;
        int c;
        m = 0;
        for (int i = 0; i < MAX_RD; i++) begin
            if (i < num_rd) begin
                c = int'(cnts[i*MAX_CNT_W +: MAX_CNT_W]);
                if (c > m) m = c;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/kernel_bc_fanout_fifo_rd_ctrl.sv
// One reader's view of the shared ring: its read pointer, its private
// occupancy count and its registered data-valid flag.
module kernel_bc_fanout_fifo_rd_ctrl
    import kernel_bc_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 2,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_acc,
    input  logic                  rd_req,
    output logic                  rd_acc,
    output logic [ADDR_WIDTH-1:0] rd_ptr,
    output logic [ADDR_WIDTH:0]   cnt_next,
    output logic                  empty_n
);

    localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH+1)'(1);

    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic                  empty_n_q, empty_n_d;

    // Accept, pointer advance and count update for this reader.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch.
        rd_acc    = rd_req & empty_n_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        if (rd_acc) begin
            rd_ptr_d = ADDR_WIDTH'(ptr_inc(int'(rd_ptr_q), DEPTH));
        end
        case ({wr_acc, rd_acc})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
        empty_n_d = (cnt_d != '0);
    end

    // Reader state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            empty_n_q <= 1'b0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            empty_n_q <= empty_n_d;
        end
    end

    assign rd_ptr   = rd_ptr_q;
    assign cnt_next = cnt_d;
    assign empty_n  = empty_n_q;

endmodule

// File: rtl/kernel_bc_start_fanout_fifo.sv
// Broadcast start/token FIFO: one writer, NUM_RD readers that each see
// every word. A slot is reused only after the slowest reader drains it.
module kernel_bc_start_fanout_fifo
    import kernel_bc_fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = 1,
    parameter int ADDR_WIDTH   = 2,
    parameter int DEPTH        = 4,
    parameter int NUM_RD       = 2,
    parameter int AFULL_THRESH = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DATA_WIDTH-1:0]        if_din,
    input  logic                         if_write,
    input  logic                         if_write_ce,
    output logic                         if_full_n,
    output logic                         if_almost_full_n,
    output logic [ADDR_WIDTH:0]          if_count,
    input  logic [NUM_RD-1:0]            if_read,
    input  logic [NUM_RD-1:0]            if_read_ce,
    output logic [NUM_RD-1:0]            if_empty_n,
    output logic [NUM_RD*DATA_WIDTH-1:0] if_dout
);

    if (!params_legal(ADDR_WIDTH, DEPTH, NUM_RD, AFULL_THRESH)) begin : g_bad_params
        $error("kernel_bc_start_fanout_fifo: illegal parameter combination");
    end

    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_C = (ADDR_WIDTH+1)'(AFULL_THRESH);

    logic [DATA_WIDTH-1:0]            mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0]            wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]              count_q, count_d;
    logic                             full_n_q, full_n_d;
    logic                             almost_full_n_q, almost_full_n_d;
    logic                             wr_acc;
    logic [NUM_RD-1:0]                rd_req;
    logic [NUM_RD-1:0]                rd_acc;
    logic [NUM_RD-1:0][ADDR_WIDTH-1:0] rd_ptr;
    logic [NUM_RD-1:0][ADDR_WIDTH:0]  cnt_next;
    cnt_vec_t                         cnt_vec;

    // Nothing is accepted while reset is held, so reset discards cleanly.
    assign wr_acc = if_write & if_write_ce & full_n_q & ~reset;
    assign rd_req = if_read & if_read_ce & {NUM_RD{~reset}};

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        kernel_bc_fanout_fifo_rd_ctrl #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .DEPTH      (DEPTH)
        ) u_rd_ctrl (
            .clk      (clk),
            .reset    (reset),
            .wr_acc   (wr_acc),
            .rd_req   (rd_req[i]),
            .rd_acc   (rd_acc[i]),
            .rd_ptr   (rd_ptr[i]),
            .cnt_next (cnt_next[i]),
            .empty_n  (if_empty_n[i])
        );

        // First-word-fall-through: each reader sees the slot it points at.
        assign if_dout[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[rd_ptr[i]];
    end

    // Write pointer advance plus global occupancy and flags from next-state counts.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        if (wr_acc) begin
            wr_ptr_d = ADDR_WIDTH'(ptr_inc(int'(wr_ptr_q), DEPTH));
        end
        cnt_vec = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            cnt_vec[i*MAX_CNT_W +: MAX_CNT_W] = MAX_CNT_W'(cnt_next[i]);
        end
        count_d         = (ADDR_WIDTH+1)'(max_cnt(cnt_vec, NUM_RD));
        full_n_d        = (count_d < DEPTH_C);
        almost_full_n_d = (count_d < AFULL_C);
    end

    // Writer-side state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q        <= '0;
            count_q         <= '0;
            full_n_q        <= 1'b1;
            almost_full_n_q <= 1'b1;
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            count_q         <= count_d;
            full_n_q        <= full_n_d;
            almost_full_n_q <= almost_full_n_d;
        end
    end

    // Storage write.
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; empty flags gate its contents, so reset would only cost area.
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= if_din;
        end
    end

    assign if_full_n        = full_n_q;
    assign if_almost_full_n = almost_full_n_q;
    assign if_count         = count_q;

    // rd_acc is part of each reader's own state update; kept visible here for debug.
    logic unused_rd_acc;
    assign unused_rd_acc = ^rd_acc;

endmodule

// File: tb/tb_kernel_bc_start_fanout_fifo.sv
// Directed bench for the broadcast start FIFO: a DEPTH=4 instance for
// fan-out, fill, skew, simultaneous access and reset, and a DEPTH=3
// instance for non-power-of-two wrap.
module tb_kernel_bc_start_fanout_fifo;

    logic       clk = 1'b0;
    logic       reset;

    logic [3:0] a_din;
    logic       a_write, a_write_ce;
    logic       a_full_n, a_afull_n;
    logic [2:0] a_count;
    logic [1:0] a_read, a_read_ce, a_empty_n;
    logic [7:0] a_dout;

    logic [3:0] b_din;
    logic       b_write, b_write_ce;
    logic       b_full_n, b_afull_n;
    logic [2:0] b_count;
    logic [1:0] b_read, b_read_ce, b_empty_n;
    logic [7:0] b_dout;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    kernel_bc_start_fanout_fifo #(
        .DATA_WIDTH(4), .ADDR_WIDTH(2), .DEPTH(4), .NUM_RD(2), .AFULL_THRESH(3)
    ) dut_a (
        .clk(clk), .reset(reset), .if_din(a_din), .if_write(a_write),
        .if_write_ce(a_write_ce), .if_full_n(a_full_n), .if_almost_full_n(a_afull_n),
        .if_count(a_count), .if_read(a_read), .if_read_ce(a_read_ce),
        .if_empty_n(a_empty_n), .if_dout(a_dout)
    );

    kernel_bc_start_fanout_fifo #(
        .DATA_WIDTH(4), .ADDR_WIDTH(2), .DEPTH(3), .NUM_RD(2), .AFULL_THRESH(2)
    ) dut_b (
        .clk(clk), .reset(reset), .if_din(b_din), .if_write(b_write),
        .if_write_ce(b_write_ce), .if_full_n(b_full_n), .if_almost_full_n(b_afull_n),
        .if_count(b_count), .if_read(b_read), .if_read_ce(b_read_ce),
        .if_empty_n(b_empty_n), .if_dout(b_dout)
    );

    // Advance one clock and sample just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        n_checks++; if (a_full_n !== 1'b1) begin n_errors++; $display("FAIL reset_full_n got %0b exp 1", a_full_n); end
        n_checks++; if (a_afull_n !== 1'b1) begin n_errors++; $display("FAIL reset_afull_n got %0b exp 1", a_afull_n); end
        n_checks++; if (a_count !== 3'd0) begin n_errors++; $display("FAIL reset_count got %0d exp 0", a_count); end
        n_checks++; if (a_empty_n !== 2'b00) begin n_errors++; $display("FAIL reset_empty_n got %b exp 00", a_empty_n); end
        n_checks++; if (b_empty_n !== 2'b00) begin n_errors++; $display("FAIL reset_b_empty_n got %b exp 00", b_empty_n); end
        step();
        step();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic_fanout();
        a_write = 1'b1;
        a_din = 4'hA; step();
        a_din = 4'hB; step();
        a_din = 4'hC; step();
        a_write = 1'b0;
        n_checks++; if (a_count !== 3'd3) begin n_errors++; $display("FAIL basic_count got %0d exp 3", a_count); end
        n_checks++; if (a_afull_n !== 1'b0) begin n_errors++; $display("FAIL basic_afull_n got %0b exp 0", a_afull_n); end
        n_checks++; if (a_full_n !== 1'b1) begin n_errors++; $display("FAIL basic_full_n got %0b exp 1", a_full_n); end
        n_checks++; if (a_empty_n !== 2'b11) begin n_errors++; $display("FAIL basic_empty_n got %b exp 11", a_empty_n); end
        n_checks++; if (a_dout[3:0] !== 4'hA) begin n_errors++; $display("FAIL basic_dout0 got %h exp a", a_dout[3:0]); end
        n_checks++; if (a_dout[7:4] !== 4'hA) begin n_errors++; $display("FAIL basic_dout1 got %h exp a", a_dout[7:4]); end
        // Write without clock-enable must be ignored.
        a_write = 1'b1; a_write_ce = 1'b0; a_din = 4'hF; step();
        a_write = 1'b0; a_write_ce = 1'b1;
        n_checks++; if (a_count !== 3'd3) begin n_errors++; $display("FAIL basic_ce_count got %0d exp 3", a_count); end
        a_read = 2'b01;
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (a_dout[3:0] !== 4'(4'hA + k)) begin n_errors++; $display("FAIL basic_drain0[%0d] got %h exp %h", k, a_dout[3:0], 4'(4'hA + k)); end
            step();
        end
        a_read = 2'b00;
        n_checks++; if (a_empty_n !== 2'b10) begin n_errors++; $display("FAIL basic_mid_empty_n got %b exp 10", a_empty_n); end
        n_checks++; if (a_count !== 3'd3) begin n_errors++; $display("FAIL basic_mid_count got %0d exp 3", a_count); end
        n_checks++; if (a_dout[7:4] !== 4'hA) begin n_errors++; $display("FAIL basic_mid_dout1 got %h exp a", a_dout[7:4]); end
        a_read = 2'b10;
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (a_dout[7:4] !== 4'(4'hA + k)) begin n_errors++; $display("FAIL basic_drain1[%0d] got %h exp %h", k, a_dout[7:4], 4'(4'hA + k)); end
            step();
        end
        a_read = 2'b00;
        n_checks++; if (a_empty_n !== 2'b00) begin n_errors++; $display("FAIL basic_end_empty_n got %b exp 00", a_empty_n); end
        n_checks++; if (a_count !== 3'd0) begin n_errors++; $display("FAIL basic_end_count got %0d exp 0", a_count); end
        n_checks++; if (a_afull_n !== 1'b1) begin n_errors++; $display("FAIL basic_end_afull_n got %0b exp 1", a_afull_n); end
    endtask

    task automatic test_fill_block();
        a_write = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            a_din = 4'(k);
            step();
        end
        n_checks++; if (a_full_n !== 1'b0) begin n_errors++; $display("FAIL fill_full_n got %0b exp 0", a_full_n); end
        n_checks++; if (a_count !== 3'd4) begin n_errors++; $display("FAIL fill_count got %0d exp 4", a_count); end
        a_din = 4'hF; step();
        a_write = 1'b0;
        n_checks++; if (a_count !== 3'd4) begin n_errors++; $display("FAIL fill_blocked_count got %0d exp 4", a_count); end
        n_checks++; if (a_full_n !== 1'b0) begin n_errors++; $display("FAIL fill_blocked_full_n got %0b exp 0", a_full_n); end
        a_read = 2'b11;
        for (int k = 1; k <= 4; k++) begin
            n_checks++; if (a_dout[3:0] !== 4'(k)) begin n_errors++; $display("FAIL fill_dout0[%0d] got %h exp %h", k, a_dout[3:0], 4'(k)); end
            n_checks++; if (a_dout[7:4] !== 4'(k)) begin n_errors++; $display("FAIL fill_dout1[%0d] got %h exp %h", k, a_dout[7:4], 4'(k)); end
            step();
        end
        n_checks++; if (a_empty_n !== 2'b00) begin n_errors++; $display("FAIL fill_drained_empty_n got %b exp 00", a_empty_n); end
        n_checks++; if (a_full_n !== 1'b1) begin n_errors++; $display("FAIL fill_drained_full_n got %0b exp 1", a_full_n); end
        // Read while empty is ignored.
        step();
        a_read = 2'b00;
        n_checks++; if (a_count !== 3'd0) begin n_errors++; $display("FAIL fill_underflow_count got %0d exp 0", a_count); end
        a_write = 1'b1; a_din = 4'h5; step();
        a_write = 1'b0;
        n_checks++; if (a_dout !== 8'h55) begin n_errors++; $display("FAIL fill_after_dout got %h exp 55", a_dout); end
        n_checks++; if (a_count !== 3'd1) begin n_errors++; $display("FAIL fill_after_count got %0d exp 1", a_count); end
        a_read = 2'b11; step();
        a_read = 2'b00;
        n_checks++; if (a_empty_n !== 2'b00) begin n_errors++; $display("FAIL fill_end_empty_n got %b exp 00", a_empty_n); end
    endtask

    task automatic test_skewed();
        a_write = 1'b1;
        for (int k = 6; k <= 9; k++) begin
            a_din = 4'(k);
            step();
        end
        a_write = 1'b0;
        a_read = 2'b01;
        for (int k = 6; k <= 9; k++) begin
            n_checks++; if (a_dout[3:0] !== 4'(k)) begin n_errors++; $display("FAIL skew_dout0[%0d] got %h exp %h", k, a_dout[3:0], 4'(k)); end
            step();
        end
        a_read = 2'b00;
        n_checks++; if (a_empty_n !== 2'b10) begin n_errors++; $display("FAIL skew_empty_n got %b exp 10", a_empty_n); end
        n_checks++; if (a_count !== 3'd4) begin n_errors++; $display("FAIL skew_count got %0d exp 4", a_count); end
        n_checks++; if (a_full_n !== 1'b0) begin n_errors++; $display("FAIL skew_full_n got %0b exp 0", a_full_n); end
        a_read = 2'b10;
        n_checks++; if (a_dout[7:4] !== 4'h6) begin n_errors++; $display("FAIL skew_dout1_first got %h exp 6", a_dout[7:4]); end
        step();
        a_read = 2'b00;
        n_checks++; if (a_full_n !== 1'b1) begin n_errors++; $display("FAIL skew_free_full_n got %0b exp 1", a_full_n); end
        n_checks++; if (a_count !== 3'd3) begin n_errors++; $display("FAIL skew_free_count got %0d exp 3", a_count); end
        n_checks++; if (a_afull_n !== 1'b0) begin n_errors++; $display("FAIL skew_free_afull_n got %0b exp 0", a_afull_n); end
        a_read = 2'b10;
        for (int k = 7; k <= 9; k++) begin
            n_checks++; if (a_dout[7:4] !== 4'(k)) begin n_errors++; $display("FAIL skew_dout1[%0d] got %h exp %h", k, a_dout[7:4], 4'(k)); end
            step();
        end
        a_read = 2'b00;
        n_checks++; if (a_count !== 3'd0) begin n_errors++; $display("FAIL skew_end_count got %0d exp 0", a_count); end
    endtask

    task automatic test_back_to_back();
        a_write = 1'b1;
        a_din = 4'h1; step();
        a_din = 4'h2; step();
        a_read = 2'b11;
        a_din = 4'h3;
        n_checks++; if (a_dout !== 8'h11) begin n_errors++; $display("FAIL b2b_dout_pre got %h exp 11", a_dout); end
        step();
        n_checks++; if (a_count !== 3'd2) begin n_errors++; $display("FAIL b2b_count1 got %0d exp 2", a_count); end
        n_checks++; if (a_full_n !== 1'b1) begin n_errors++; $display("FAIL b2b_full_n got %0b exp 1", a_full_n); end
        n_checks++; if (a_afull_n !== 1'b1) begin n_errors++; $display("FAIL b2b_afull_n got %0b exp 1", a_afull_n); end
        n_checks++; if (a_empty_n !== 2'b11) begin n_errors++; $display("FAIL b2b_empty_n got %b exp 11", a_empty_n); end
        n_checks++; if (a_dout !== 8'h22) begin n_errors++; $display("FAIL b2b_dout1 got %h exp 22", a_dout); end
        a_din = 4'h4; step();
        n_checks++; if (a_count !== 3'd2) begin n_errors++; $display("FAIL b2b_count2 got %0d exp 2", a_count); end
        n_checks++; if (a_dout !== 8'h33) begin n_errors++; $display("FAIL b2b_dout2 got %h exp 33", a_dout); end
        a_write = 1'b0;
        step();
        n_checks++; if (a_dout !== 8'h44) begin n_errors++; $display("FAIL b2b_dout3 got %h exp 44", a_dout); end
        step();
        a_read = 2'b00;
        n_checks++; if (a_empty_n !== 2'b00) begin n_errors++; $display("FAIL b2b_end_empty_n got %b exp 00", a_empty_n); end
    endtask

    task automatic test_wrap_depth3();
        for (int k = 0; k < 10; k++) begin
            b_din = 4'(k); b_write = 1'b1; step();
            b_write = 1'b0;
            n_checks++; if (b_count !== 3'd1) begin n_errors++; $display("FAIL wrap_count[%0d] got %0d exp 1", k, b_count); end
            n_checks++; if (b_dout !== {4'(k), 4'(k)}) begin n_errors++; $display("FAIL wrap_dout[%0d] got %h exp %h", k, b_dout, {4'(k), 4'(k)}); end
            b_read = 2'b11; step();
            b_read = 2'b00;
            n_checks++; if (b_empty_n !== 2'b00) begin n_errors++; $display("FAIL wrap_empty_n[%0d] got %b exp 00", k, b_empty_n); end
        end
        b_write = 1'b1;
        for (int k = 10; k <= 12; k++) begin
            b_din = 4'(k);
            step();
        end
        b_write = 1'b0;
        n_checks++; if (b_full_n !== 1'b0) begin n_errors++; $display("FAIL wrap_full_n got %0b exp 0", b_full_n); end
        n_checks++; if (b_count !== 3'd3) begin n_errors++; $display("FAIL wrap_full_count got %0d exp 3", b_count); end
        n_checks++; if (b_afull_n !== 1'b0) begin n_errors++; $display("FAIL wrap_afull_n got %0b exp 0", b_afull_n); end
        b_read = 2'b11;
        for (int k = 10; k <= 12; k++) begin
            n_checks++; if (b_dout !== {4'(k), 4'(k)}) begin n_errors++; $display("FAIL wrap_drain[%0d] got %h exp %h", k, b_dout, {4'(k), 4'(k)}); end
            step();
        end
        b_read = 2'b00;
        n_checks++; if (b_count !== 3'd0) begin n_errors++; $display("FAIL wrap_end_count got %0d exp 0", b_count); end
    endtask

    task automatic test_async_reset();
        a_write = 1'b1;
        a_din = 4'h1; step();
        a_din = 4'h2; step();
        a_din = 4'h7;
        n_checks++; if (a_count !== 3'd2) begin n_errors++; $display("FAIL arst_pre_count got %0d exp 2", a_count); end
        #2;
        reset = 1'b1;
        #1;
        n_checks++; if (a_empty_n !== 2'b00) begin n_errors++; $display("FAIL arst_empty_n got %b exp 00", a_empty_n); end
        n_checks++; if (a_full_n !== 1'b1) begin n_errors++; $display("FAIL arst_full_n got %0b exp 1", a_full_n); end
        n_checks++; if (a_count !== 3'd0) begin n_errors++; $display("FAIL arst_count got %0d exp 0", a_count); end
        n_checks++; if (a_afull_n !== 1'b1) begin n_errors++; $display("FAIL arst_afull_n got %0b exp 1", a_afull_n); end
        step();
        n_checks++; if (a_count !== 3'd0) begin n_errors++; $display("FAIL arst_held_count got %0d exp 0", a_count); end
        @(negedge clk);
        reset = 1'b0;
        a_din = 4'hD;
        step();
        a_write = 1'b0;
        n_checks++; if (a_empty_n !== 2'b11) begin n_errors++; $display("FAIL arst_post_empty_n got %b exp 11", a_empty_n); end
        n_checks++; if (a_dout !== 8'hDD) begin n_errors++; $display("FAIL arst_post_dout got %h exp dd", a_dout); end
        n_checks++; if (a_count !== 3'd1) begin n_errors++; $display("FAIL arst_post_count got %0d exp 1", a_count); end
    endtask

    initial begin
        reset = 1'b1;
        a_din = '0; a_write = 1'b0; a_write_ce = 1'b1; a_read = '0; a_read_ce = 2'b11;
        b_din = '0; b_write = 1'b0; b_write_ce = 1'b1; b_read = '0; b_read_ce = 2'b11;
        test_reset();
        test_basic_fanout();
        test_fill_block();
        test_skewed();
        test_back_to_back();
        test_wrap_depth3();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
